sdc_dma_wb_postbuf: RTL
=======================

// Module: sdc_dma_wb_postbuf
// PURPOSE
//  Posted-write buffer and classic-to-pipelined Wishbone bridge for the SD controller DMA master.
//  Sits between the SD controller's classic WB master port and the pipelined WB-to-AXI master.
//  Card-to-memory DMA writes are acked immediately and drained in bursts.
//  Reads stay strictly ordered behind all buffered writes.
// PARAMETERS
//  AW       30  word-address width
//  DW       32  data width; SEL width = DW/8
//  LGFIFO   3   log2 of posted-write FIFO depth (8 entries of {addr,data,sel})
//  MAX_OUT  4   max pipelined requests awaiting ack on the master side (1..2**LGFIFO)
// PORTS
//  i_clk      in   1      clock
//  i_reset    in   1      synchronous, active-high reset
//  i_scyc     in   1      classic slave: cycle
//  i_sstb     in   1      classic slave: strobe
//  i_swe      in   1      classic slave: write enable
//  i_saddr    in   AW     classic slave: word address
//  i_sdata    in   DW     classic slave: write data
//  i_ssel     in   DW/8   classic slave: byte select
//  o_sack     out  1      classic slave: ack, one-cycle pulse
//  o_sdata    out  DW     classic slave: read data, valid with o_sack
//  o_serr     out  1      classic slave: error, one-cycle pulse
//  o_mcyc     out  1      pipelined master: cycle
//  o_mstb     out  1      pipelined master: strobe
//  o_mwe      out  1      pipelined master: write enable
//  o_maddr    out  AW     pipelined master: address
//  o_mdata    out  DW     pipelined master: write data
//  o_msel     out  DW/8   pipelined master: byte select
//  i_mstall   in   1      pipelined master: stall
//  i_mack     in   1      pipelined master: ack
//  i_mdata    in   DW     pipelined master: read data
//  i_merr     in   1      pipelined master: error
//  o_werr     out  1      sticky flag: a posted write was errored
//  i_werr_clr in   1      clears o_werr
// BEHAVIOUR
//  Reset: outputs 0, FIFO empty, outstanding count = 0, FSM = M_IDLE, o_werr = 0.
//  Reset mid-transfer: same state, effective the next cycle. Buffered writes are lost.
//  Slave request: req = i_scyc & i_sstb & ~o_sack & ~o_serr. The ack/err cycle is never a new request.
//  Write post: req & i_swe & FIFO not full pushes {addr,data,sel}. o_sack pulses the next cycle (latency 1).
//    FIFO full: no ack; the request is held until a slot frees.
//  Read: req & ~i_swe is accepted only in M_IDLE with FIFO empty and outstanding = 0. Otherwise it waits.
//  Master FSM:
//   M_IDLE:  FIFO not empty -> M_WRITE. Accepted read -> M_RD_REQ with the address, data and sel latched.
//   M_WRITE: o_mcyc=1; o_mwe=1. o_mstb=1 while FIFO not empty and outstanding < MAX_OUT.
//     A write is issued when o_mstb & ~i_mstall: the FIFO pops and outstanding increments.
//     Each i_mack decrements outstanding.
//     When issue and ack happen in the same cycle, outstanding is unchanged.
//     FIFO empty and outstanding = 0 -> o_mcyc=0, go to M_IDLE.
//     Writes pushed during M_WRITE join the same cycle (no cyc drop).
//   M_RD_REQ: o_mcyc=1; o_mstb=1; o_mwe=0. On ~i_mstall -> M_RD_ACK.
//   M_RD_ACK: o_mstb=0. On i_mack, o_sdata <= i_mdata and o_sack pulses. On i_merr, o_serr pulses.
//     In both cases o_mcyc drops -> M_IDLE.
//  Write error: i_merr in M_WRITE sets o_werr, flushes the FIFO, clears outstanding and drops o_mcyc -> M_IDLE.
//    Slave writes acked in the error cycle are discarded.
//  o_werr stays set until i_werr_clr. A set in the same cycle as a clear wins.
//  i_scyc drops during M_RD_REQ/M_RD_ACK: the bus read still completes, but no slave response is generated.
//  o_maddr, o_mdata and o_msel are stable while o_mstb & i_mstall.
//  Bursts never exceed MAX_OUT requests awaiting ack.
// TESTING
//  8 back-to-back writes to 0x100..0x107 with i_mstall=0 and ack latency 2 -> 8 o_sack pulses at latency 1.
//    The master side shows one cyc, 8 stb beats in order, and outstanding never exceeds 4.
//  12 writes with i_mstall=1 -> the first 8 acked, the 9th held until i_mstall releases.
//    Master-side order is 0..11; no beat is dropped or duplicated.
//  Write to 0x20 then read of 0x20 -> the read stb appears only after the write ack.
//    o_sdata = i_mdata; o_sack is one cycle.
//  i_merr on the 2nd of 4 posted writes -> o_werr=1, remaining entries are not issued, o_mcyc drops.
//    o_werr stays 1 until i_werr_clr.
//  Read with i_merr -> o_serr pulses once, o_sack stays 0, FSM returns to M_IDLE.
//  i_reset asserted during M_WRITE with 3 entries -> the next cycle has all outputs 0, FIFO empty.
//    A following write is handled normally.

Source files
------------

// File: rtl/sdc_dma_wb_postbuf.sv
// Posted-write buffer and classic-to-pipelined Wishbone bridge for the
// SD controller DMA master; reads stay ordered behind buffered writes.
module sdc_dma_wb_postbuf #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int LGFIFO  = 3,
    parameter int MAX_OUT = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_scyc,
    input  logic            i_sstb,
    input  logic            i_swe,
    input  logic [AW-1:0]   i_saddr,
    input  logic [DW-1:0]   i_sdata,
    input  logic [DW/8-1:0] i_ssel,
    output logic            o_sack,
    output logic [DW-1:0]   o_sdata,
    output logic            o_serr,
    output logic            o_mcyc,
    output logic            o_mstb,
    output logic            o_mwe,
    output logic [AW-1:0]   o_maddr,
    output logic [DW-1:0]   o_mdata,
    output logic [DW/8-1:0] o_msel,
    input  logic            i_mstall,
    input  logic            i_mack,
    input  logic [DW-1:0]   i_mdata,
    input  logic            i_merr,
    output logic            o_werr,
    input  logic            i_werr_clr
);
    localparam int SW    = DW / 8;
    localparam int EW    = AW + DW + SW;
    localparam int DEPTH = 1 << LGFIFO;
    localparam int OW    = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        M_IDLE,
        M_WRITE,
        M_RD_REQ,
        M_RD_ACK
    } mstate_t;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   head;
    logic [LGFIFO:0] wr_q, wr_d, rd_q, rd_d;
    logic [OW-1:0]   out_q, out_d;
    mstate_t         st_q, st_d;
    logic            mcyc_q, mcyc_d, mstb_q, mstb_d, mwe_q, mwe_d;
    logic            sack_q, sack_d, serr_q, serr_d;
    logic            werr_q, werr_d, rlive_q, rlive_d;
    logic [DW-1:0]   sdata_q, sdata_d, rdat_q, rdat_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [SW-1:0]   rsel_q, rsel_d;
    logic            empty, full, req, push, issue, rd_acc, wack;

    assign empty  = (wr_q == rd_q);
    assign full   = (wr_q[LGFIFO] != rd_q[LGFIFO]) &&
                    (wr_q[LGFIFO-1:0] == rd_q[LGFIFO-1:0]);
    assign req    = i_scyc & i_sstb & ~sack_q & ~serr_q;
    assign push   = req & i_swe & ~full;
    assign issue  = (st_q == M_WRITE) & mstb_q & ~i_mstall;
    assign rd_acc = req & ~i_swe & (st_q == M_IDLE) & empty & (out_q == '0);
    assign wack   = i_mack & (out_q != '0);
    assign head   = mem_q[rd_q[LGFIFO-1:0]];

    always_ff @(posedge i_clk) begin
        if (push)
            mem_q[wr_q[LGFIFO-1:0]] <= {i_saddr, i_sdata, i_ssel};
    end

    always_comb begin
        st_d    = st_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        out_d   = out_q;
        sack_d  = 1'b0;
        serr_d  = 1'b0;
        sdata_d = sdata_q;
        raddr_d = raddr_q;
        rdat_d  = rdat_q;
        rsel_d  = rsel_q;
        rlive_d = rlive_q & i_scyc;
        werr_d  = i_werr_clr ? 1'b0 : werr_q;
        if (push) begin
            wr_d   = wr_q + 1'b1;
            sack_d = 1'b1;
        end
        if (issue)
            rd_d = rd_q + 1'b1;
        unique case (st_q)
            M_IDLE: begin
                if (wr_d != rd_d) begin
                    st_d = M_WRITE;
                end else if (rd_acc) begin
                    st_d    = M_RD_REQ;
                    raddr_d = i_saddr;
                    rdat_d  = i_sdata;
                    rsel_d  = i_ssel;
                    rlive_d = 1'b1;
                end
            end
            M_WRITE: begin
                // An error abandons the burst, including a write posted now
                if (i_merr) begin
                    werr_d = 1'b1;
                    wr_d   = '0;
                    rd_d   = '0;
                    out_d  = '0;
                    st_d   = M_IDLE;
                end else begin
                    out_d = out_q + OW'(issue) - OW'(wack);
                    if (wr_d == rd_d && out_d == '0)
                        st_d = M_IDLE;
                end
            end
            M_RD_REQ: begin
                if (!i_mstall)
                    st_d = M_RD_ACK;
            end
            M_RD_ACK: begin
                if (i_merr) begin
                    serr_d = rlive_d;
                    st_d   = M_IDLE;
                end else if (i_mack) begin
                    sack_d  = sack_d | rlive_d;
                    sdata_d = i_mdata;
                    st_d    = M_IDLE;
                end
            end
            default: st_d = M_IDLE;
        endcase
        mcyc_d = (st_d != M_IDLE);
        mwe_d  = (st_d == M_WRITE);
        mstb_d = (st_d == M_RD_REQ) ||
                 ((st_d == M_WRITE) && (wr_d != rd_d) &&
                  (out_d < OW'(MAX_OUT)));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            st_q    <= M_IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            out_q   <= '0;
            mcyc_q  <= 1'b0;
            mstb_q  <= 1'b0;
            mwe_q   <= 1'b0;
            sack_q  <= 1'b0;
            serr_q  <= 1'b0;
            werr_q  <= 1'b0;
            rlive_q <= 1'b0;
            sdata_q <= '0;
            raddr_q <= '0;
            rdat_q  <= '0;
            rsel_q  <= '0;
        end else begin
            st_q    <= st_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            out_q   <= out_d;
            mcyc_q  <= mcyc_d;
            mstb_q  <= mstb_d;
            mwe_q   <= mwe_d;
            sack_q  <= sack_d;
            serr_q  <= serr_d;
            werr_q  <= werr_d;
            rlive_q <= rlive_d;
            sdata_q <= sdata_d;
            raddr_q <= raddr_d;
            rdat_q  <= rdat_d;
            rsel_q  <= rsel_d;
        end
    end

    assign o_mcyc  = mcyc_q;
    assign o_mstb  = mstb_q;
    assign o_mwe   = mwe_q;
    assign {o_maddr, o_mdata, o_msel} =
        (st_q == M_WRITE) ? head : {raddr_q, rdat_q, rsel_q};
    assign o_sack  = sack_q;
    assign o_serr  = serr_q;
    assign o_sdata = sdata_q;
    assign o_werr  = werr_q;
endmodule
